// File: rtl/rv32e_writeback.sv
// rv32e_writeback: merges ALU/LSU results onto the regfile write port with starvation-bounded arbitration and a long-op scoreboard
module rv32e_writeback #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [3:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [3:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  input  logic        iss_valid,
  input  logic        iss_long,
  input  logic [3:0]  iss_rd,
  input  logic [3:0]  iss_rs1,
  input  logic [3:0]  iss_rs2,
  output logic        iss_ready,
  output logic [15:0] busy,
  output logic        wb_we,
  output logic [3:0]  wb_rd,
  output logic [31:0] wb_data
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);
  typedef enum logic {ALU_PRI, LSU_FORCE} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0] busy_q, busy_d, set_v, clr_v;
  logic lsu_starve, alu_acc, lsu_acc;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ALU_PRI;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  // The LSU is forced in on the cycle right after its STARVE_MAX-th loss.
  always_comb begin
    lsu_starve = lsu_valid & ~lsu_ready;
    cnt_d = lsu_starve ? ((cnt_q == SMAX) ? cnt_q : cnt_q + CW'(1)) : '0;
    state_d = (state_q == ALU_PRI && lsu_starve && cnt_d == SMAX) ? LSU_FORCE : ALU_PRI;
  end
  always_comb begin
    alu_ready = (state_q == ALU_PRI) & alu_valid;
    lsu_ready = lsu_valid & ((state_q == LSU_FORCE) | ~alu_valid);
  end
  assign alu_acc = alu_valid & alu_ready;
  assign lsu_acc = lsu_valid & lsu_ready;
  assign iss_ready = ~busy_q[iss_rs1] & ~busy_q[iss_rs2] & ~busy_q[iss_rd];
  // Set after clear so a same-cycle reissue of rd keeps it busy.
  always_comb begin
    set_v = (iss_valid & iss_ready & iss_long) ? (16'd1 << iss_rd) : '0;
    clr_v = lsu_acc ? (16'd1 << lsu_rd) : '0;
    busy_d = ((busy_q & ~clr_v) | set_v) & 16'hFFFE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      wb_we <= 1'b0;
      wb_rd <= '0;
      wb_data <= '0;
    end else begin
      busy_q <= busy_d;
      wb_we <= (lsu_acc & (lsu_rd != 4'd0)) | (alu_acc & (alu_rd != 4'd0));
      if (lsu_acc) begin
        wb_rd <= lsu_rd;
        wb_data <= lsu_data;
      end else if (alu_acc) begin
        wb_rd <= alu_rd;
        wb_data <= alu_data;
      end
    end
  end
  assign busy = busy_q;
endmodule

// File: tb/tb_rv32e_writeback.sv
// tb_rv32e_writeback: directed-vector bench for rv32e_writeback
module tb_rv32e_writeback;
  logic clk = 1'b0, rst = 1'b1;
  logic alu_valid = 0, lsu_valid = 0, iss_valid = 0, iss_long = 0;
  logic alu_ready, lsu_ready, iss_ready, wb_we;
  logic [3:0] alu_rd = 0, lsu_rd = 0, iss_rd = 0, iss_rs1 = 0, iss_rs2 = 0, wb_rd;
  logic [31:0] alu_data = 0, lsu_data = 0, wb_data;
  logic [15:0] busy;
  int nvec = 0, nerr = 0;
  always #5 clk = ~clk;
  rv32e_writeback #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .iss_valid(iss_valid), .iss_long(iss_long), .iss_rd(iss_rd), .iss_rs1(iss_rs1),
    .iss_rs2(iss_rs2), .iss_ready(iss_ready), .busy(busy),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue_long(input logic [3:0] rd);
    iss_valid = 1; iss_long = 1; iss_rd = rd; iss_rs1 = 0; iss_rs2 = 0;
    tick();
    iss_valid = 0; iss_long = 0; iss_rd = 0;
  endtask
  initial begin
    tick(); tick();
    chk("rst_we", wb_we, 0);
    chk("rst_rd", wb_rd, 0);
    chk("rst_data", wb_data, 0);
    chk("rst_busy", busy, 0);
    rst = 0;
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    #1 chk("alu_rdy", alu_ready, 1);
    tick();
    alu_valid = 0;
    chk("alu_we", wb_we, 1);
    chk("alu_rd", wb_rd, 5);
    chk("alu_data", wb_data, 32'hDEADBEEF);
    tick();
    chk("idle_we", wb_we, 0);
    chk("idle_hold", wb_data, 32'hDEADBEEF);
    alu_valid = 1; alu_rd = 1; lsu_valid = 1; lsu_rd = 2; lsu_data = 32'h55;
    for (int i = 1; i <= 4; i++) begin
      alu_data = i;
      #1 chk($sformatf("cont%0d_alu", i), alu_ready, 1);
      chk($sformatf("cont%0d_lsu", i), lsu_ready, 0);
      tick();
      chk($sformatf("cont%0d_wb", i), wb_data, i);
    end
    #1 chk("force_lsu", lsu_ready, 1);
    chk("force_alu", alu_ready, 0);
    tick();
    chk("force_we", wb_we, 1);
    chk("force_rd", wb_rd, 2);
    chk("force_data", wb_data, 32'h55);
    #1 chk("back_alu", alu_ready, 1);
    chk("back_lsu", lsu_ready, 0);
    lsu_valid = 0; alu_valid = 0;
    tick();
    lsu_valid = 1; lsu_rd = 0; lsu_data = 32'd123;
    #1 chk("x0_rdy", lsu_ready, 1);
    tick();
    lsu_valid = 0;
    chk("x0_we", wb_we, 0);
    chk("x0_data", wb_data, 32'd123);
    chk("x0_busy", busy, 0);
    issue_long(7);
    chk("sb_set", busy, 16'h0080);
    iss_valid = 1; iss_rs1 = 7; iss_rd = 8;
    #1 chk("sb_rs1_stall", iss_ready, 0);
    iss_rs1 = 0; iss_rs2 = 7;
    #1 chk("sb_rs2_stall", iss_ready, 0);
    iss_rs2 = 0;
    #1 chk("sb_free", iss_ready, 1);
    iss_valid = 0;
    lsu_valid = 1; lsu_rd = 7; lsu_data = 32'hCAFE;
    tick();
    lsu_valid = 0;
    chk("sb_clr", busy, 0);
    chk("sb_wb_rd", wb_rd, 7);
    lsu_valid = 1; lsu_rd = 3;
    issue_long(3);
    lsu_valid = 0;
    chk("collide", busy, 16'h0008);
    lsu_valid = 1; lsu_rd = 3;
    tick();
    lsu_valid = 0;
    chk("collide_clr", busy, 0);
    for (int r = 4; r <= 7; r++) issue_long(4'(r));
    chk("pre_rst_busy", busy, 16'h00F0);
    lsu_valid = 1; lsu_rd = 4; rst = 1;
    tick();
    rst = 0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_we", wb_we, 0);
    alu_valid = 1; alu_rd = 9;
    #1 chk("mid_rst_fsm", alu_ready, 1);
    chk("mid_rst_lsu", lsu_ready, 0);
    alu_valid = 0; lsu_valid = 0;
    tick();
    chk("post_rst_we", wb_we, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
